// File: rtl/reg_file_pkg.sv
// Shared CPU datapath package: default sizes and the register-index width helper.
package reg_file_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int REG_COUNT  = 8;

    function automatic int addrWidth(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One read port: output enable, hardwired-zero R0 and same-cycle write bypass.
module reg_file_rdport #(
    parameter int WIDTH   = 16,
    parameter int AW      = 3,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic             i_sel,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_regData,
    input  logic             i_wrActive,
    input  logic [AW-1:0]    i_wrAddr,
    input  logic [WIDTH-1:0] i_bus,
    output logic [WIDTH-1:0] o_data
);

    logic w_isR0;
    logic w_bypassHit;

    assign w_isR0      = ZERO_R0 && (i_addr == '0);
    assign w_bypassHit = BYPASS && i_wrActive && (i_addr == i_wrAddr);

    // R0 wins over bypass so a dropped R0 write never leaks onto the port.
    always_comb begin
        o_data = '0;
        if (i_sel && !w_isR0) begin
            if (w_bypassHit) begin
                o_data = i_bus;
            end else begin
                o_data = i_regData;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Parametrised register file: one synchronous write port, two combinational read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH   = DATA_WIDTH,
    parameter int DEPTH   = REG_COUNT,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1,
    localparam int AW     = addrWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] bus,
    input  logic             selA,
    input  logic [AW-1:0]    addrA,
    input  logic             selB,
    input  logic [AW-1:0]    addrB,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [DEPTH-1:0] written
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_written;
    logic             w_wrActive;
    logic             w_wrAccepted;

    assign w_wrActive   = en && !rst;
    assign w_wrAccepted = en && !(ZERO_R0 && (wrAddr == '0));

    // Reset has priority, so a write presented in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_written <= '0;
        end else if (w_wrAccepted) begin
            r_regs[wrAddr]    <= bus;
            r_written[wrAddr] <= 1'b1;
        end
    end

    assign written = r_written;

    reg_file_rdport #(
        .WIDTH  (WIDTH),
        .AW     (AW),
        .ZERO_R0(ZERO_R0),
        .BYPASS (BYPASS)
    ) u_portA (
        .i_sel     (selA),
        .i_addr    (addrA),
        .i_regData (r_regs[addrA]),
        .i_wrActive(w_wrActive),
        .i_wrAddr  (wrAddr),
        .i_bus     (bus),
        .o_data    (a)
    );

    reg_file_rdport #(
        .WIDTH  (WIDTH),
        .AW     (AW),
        .ZERO_R0(ZERO_R0),
        .BYPASS (BYPASS)
    ) u_portB (
        .i_sel     (selB),
        .i_addr    (addrB),
        .i_regData (r_regs[addrB]),
        .i_wrActive(w_wrActive),
        .i_wrAddr  (wrAddr),
        .i_bus     (bus),
        .o_data    (b)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a bypassing instance and a non-bypassing one share stimulus.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  wrAddr;
    logic [15:0] bus;
    logic        selA;
    logic [2:0]  addrA;
    logic        selB;
    logic [2:0]  addrB;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  written;
    logic [15:0] aNb;
    logic [15:0] bNb;
    logic [7:0]  writtenNb;

    int testsRun    = 0;
    int testsFailed = 0;

    reg_file #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .wrAddr(wrAddr), .bus(bus),
        .selA(selA), .addrA(addrA), .selB(selB), .addrB(addrB),
        .a(a), .b(b), .written(written)
    );

    reg_file #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b1), .BYPASS(1'b0)) dutNb (
        .clk(clk), .rst(rst), .en(en), .wrAddr(wrAddr), .bus(bus),
        .selA(selA), .addrA(addrA), .selB(selB), .addrB(addrB),
        .a(aNb), .b(bNb), .written(writtenNb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after each rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; wrAddr = 3'd0; bus = 16'h0000;
        selA = 1'b0; addrA = 3'd0; selB = 1'b0; addrB = 3'd0;
        tick();
        rst = 1'b0; selA = 1'b1; addrA = 3'd3; selB = 1'b1; addrB = 3'd7;
        #1;
        testsRun++;
        if (written !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_written: got %h expected %h", written, 8'h00);
        end
        testsRun++;
        if (a !== 16'h0000 || b !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ports: got a=%h b=%h expected 0000/0000", a, b);
        end
    endtask

    task automatic test_write_read();
        en = 1'b1; wrAddr = 3'd3; bus = 16'hF0F0; selA = 1'b0; selB = 1'b0;
        tick();
        en = 1'b0; selA = 1'b1; addrA = 3'd3;
        #1;
        testsRun++;
        if (a !== 16'hF0F0) begin
            testsFailed++;
            $display("[TB] FAIL write_read_a: got %h expected %h", a, 16'hF0F0);
        end
        testsRun++;
        if (written !== 8'h08) begin
            testsFailed++;
            $display("[TB] FAIL write_read_written: got %h expected %h", written, 8'h08);
        end
        selA = 1'b0;
        #1;
        testsRun++;
        if (a !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL sel_off_a: got %h expected %h", a, 16'h0000);
        end
    endtask

    task automatic test_write_disable();
        en = 1'b0; wrAddr = 3'd3; bus = 16'hCCCC; selB = 1'b1; addrB = 3'd3;
        #1;
        testsRun++;
        if (b !== 16'hF0F0) begin
            testsFailed++;
            $display("[TB] FAIL disabled_no_bypass_b: got %h expected %h", b, 16'hF0F0);
        end
        tick();
        testsRun++;
        if (b !== 16'hF0F0 || written !== 8'h08) begin
            testsFailed++;
            $display("[TB] FAIL disabled_hold: got b=%h written=%h expected F0F0/08", b, written);
        end
    endtask

    task automatic test_bypass();
        en = 1'b1; wrAddr = 3'd5; bus = 16'hCCCC;
        selA = 1'b1; addrA = 3'd5; selB = 1'b1; addrB = 3'd5;
        #1;
        testsRun++;
        if (a !== 16'hCCCC || b !== 16'hCCCC) begin
            testsFailed++;
            $display("[TB] FAIL bypass_same_cycle: got a=%h b=%h expected CCCC/CCCC", a, b);
        end
        tick();
        en = 1'b0; bus = 16'h0000;
        #1;
        testsRun++;
        if (a !== 16'hCCCC || b !== 16'hCCCC) begin
            testsFailed++;
            $display("[TB] FAIL bypass_after_edge: got a=%h b=%h expected CCCC/CCCC", a, b);
        end
        testsRun++;
        if (written !== 8'h28) begin
            testsFailed++;
            $display("[TB] FAIL bypass_written: got %h expected %h", written, 8'h28);
        end
    endtask

    task automatic test_zero_r0();
        en = 1'b1; wrAddr = 3'd0; bus = 16'hFFFF;
        selA = 1'b1; addrA = 3'd0; selB = 1'b1; addrB = 3'd0;
        #1;
        testsRun++;
        if (a !== 16'h0000 || b !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL r0_write_cycle: got a=%h b=%h expected 0000/0000", a, b);
        end
        tick();
        en = 1'b0;
        #1;
        testsRun++;
        if (a !== 16'h0000 || b !== 16'h0000 || written[0] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL r0_after: got a=%h b=%h w0=%b expected 0000/0000/0", a, b, written[0]);
        end
    endtask

    task automatic test_reset_override();
        for (int i = 1; i < 8; i++) begin
            en = 1'b1; wrAddr = 3'(i); bus = 16'(i * 16'h1111);
            tick();
        end
        en = 1'b0; selA = 1'b1; addrA = 3'd7;
        #1;
        testsRun++;
        if (a !== 16'h7777 || written !== 8'hFE) begin
            testsFailed++;
            $display("[TB] FAIL fill_all: got a=%h written=%h expected 7777/FE", a, written);
        end
        rst = 1'b1; en = 1'b1; wrAddr = 3'd4; bus = 16'h1234; addrA = 3'd4;
        #1;
        testsRun++;
        if (a !== 16'h4444) begin
            testsFailed++;
            $display("[TB] FAIL reset_cycle_no_bypass: got %h expected %h", a, 16'h4444);
        end
        tick();
        rst = 1'b0; en = 1'b0; bus = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            addrA = 3'(i); addrB = 3'(7 - i);
            #1;
            testsRun++;
            if (a !== 16'h0000 || b !== 16'h0000) begin
                testsFailed++;
                $display("[TB] FAIL post_reset_read%0d: got a=%h b=%h expected 0000/0000", i, a, b);
            end
        end
        testsRun++;
        if (written !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_written: got %h expected %h", written, 8'h00);
        end
    endtask

    task automatic test_no_bypass();
        en = 1'b1; wrAddr = 3'd2; bus = 16'hAAAA; selA = 1'b0; selB = 1'b0;
        tick();
        bus = 16'h5555; selA = 1'b1; addrA = 3'd2; selB = 1'b1; addrB = 3'd2;
        #1;
        testsRun++;
        if (aNb !== 16'hAAAA || bNb !== 16'hAAAA) begin
            testsFailed++;
            $display("[TB] FAIL nobypass_old: got a=%h b=%h expected AAAA/AAAA", aNb, bNb);
        end
        testsRun++;
        if (a !== 16'h5555) begin
            testsFailed++;
            $display("[TB] FAIL bypass_contrast: got %h expected %h", a, 16'h5555);
        end
        tick();
        en = 1'b0;
        #1;
        testsRun++;
        if (aNb !== 16'h5555 || writtenNb !== 8'h04) begin
            testsFailed++;
            $display("[TB] FAIL nobypass_new: got a=%h written=%h expected 5555/04", aNb, writtenNb);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 4; i++) begin
            en = 1'b1; wrAddr = 3'(i); bus = 16'(16'hA000 + i);
            tick();
        end
        en = 1'b0; selA = 1'b1; selB = 1'b1;
        for (int i = 1; i < 4; i++) begin
            addrA = 3'(i); addrB = 3'(i);
            #1;
            testsRun++;
            if (a !== 16'(16'hA000 + i) || bNb !== 16'(16'hA000 + i)) begin
                testsFailed++;
                $display("[TB] FAIL back_to_back_r%0d: got a=%h bNb=%h expected %h", i, a, bNb, 16'(16'hA000 + i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_disable();
        test_bypass();
        test_zero_r0();
        test_reset_override();
        test_no_bypass();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised register file replacing the single 16-bit bus register in the CPU datapath. It holds `DEPTH` registers of `WIDTH` bits and accepts one synchronous write per cycle from the shared data bus. Two independently addressed read ports feed the ALU A and B operands. Optional features are a hardwired-zero R0, same-cycle write-to-read bypass and a per-register written mask for debug.

## Interface
Parameters:
- `WIDTH`, 16: bits per register and bus width.
- `DEPTH`, 8: number of registers; a power of two, ≥ 2.
- `ZERO_R0`, 1: when 1, register 0 reads as zero and ignores writes.
- `BYPASS`, 1: when 1, a read of the register being written this cycle returns `bus` combinationally.

Ports (`AW` = clog2(`DEPTH`)):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: write enable.
- `wrAddr` in `AW`: write register index.
- `bus` in `WIDTH`: write data.
- `selA` in 1: port A output enable.
- `addrA` in `AW`: port A register index.
- `selB` in 1: port B output enable.
- `addrB` in `AW`: port B register index.
- `a` out `WIDTH`: port A data.
- `b` out `WIDTH`: port B data.
- `written` out `DEPTH`: bit i set once register i has been written since the last reset.

## Operation
- Storage: `DEPTH` × `WIDTH` flops. No memory macro.
- Write: at a rising edge with `en`=1 and `rst`=0, `regs[wrAddr]` ← `bus` and `written[wrAddr]` ← 1.
  - If `ZERO_R0`=1 and `wrAddr`=0, the write is dropped and `written[0]` stays 0.
- Reset: at a rising edge with `rst`=1, all registers and `written` clear to 0. `rst` overrides `en`; a write presented in the reset cycle is lost.
- Read port A is combinational:
  - `selA`=0: `a` = 0.
  - Else, if `BYPASS`=1, `en`=1, `rst`=0, `addrA`=`wrAddr` and the write is not to hardwired R0: `a` = `bus`.
  - Else: `a` = `regs[addrA]`.
  - Port B is identical using `selB`/`addrB`.
- Both ports may address the same register, including the one being written; each resolves independently.
- With `ZERO_R0`=1, a read of R0 returns 0 regardless of bypass.

## Timing
- Write latency: one edge. The value is visible on a non-bypassed read in the cycle after the edge.
- Bypass latency: zero. It reflects `bus` in the write cycle itself, before the edge.
- With `BYPASS`=0, a read of the register being written returns the old value until the edge.
- Reset values after the first `rst` edge:
  - `a` = `b` = 0 (registers zero).
  - `written` = 0.
- Before the first reset, register contents are undefined. The bench must reset first.
- With `rst` asserted and `sel*`=1, the outputs still show stored contents until the reset edge. Bypass is suppressed while `rst`=1.
- There are no other stalls or handshakes; a write can occur every cycle.

## Structure
- Shared CPU package holds:
  - Default datapath width (16).
  - Default register count (8).
  - The `AW` derivation helper.
- One natural sub-module, `reg_file_rdport`: the enable/bypass/R0 mux for one read port, instantiated twice.
- The storage array and `written` mask stay in the top module.

## Test plan
Defaults (`WIDTH`=16, `DEPTH`=8, `ZERO_R0`=1, `BYPASS`=1), reset first:
- Write R3 = 0xF0F0, then `selA`=1 with `addrA`=3 → `a` = 0xF0F0, `written` = 0x08. `selA`=0 → `a` = 0.
- `en`=0, `bus` = 0xCCCC, read R3 on port B → `b` stays 0xF0F0 and `written` unchanged.
- `en`=1, `wrAddr`=5, `bus` = 0xCCCC, with `addrA`=`addrB`=5 in the same cycle → `a` = `b` = 0xCCCC before the edge; after the edge `en`=0 → still 0xCCCC.
- Write R0 = 0xFFFF → read R0 on both ports = 0 (also in the write cycle), `written[0]` = 0.
- Write R1..R7 with distinct values, then `rst`=1 with `en`=1, `bus` = 0x1234 in the same cycle → all reads 0 and `written` = 0 afterward. The lost write does not appear.
- Instantiate `BYPASS`=0: write R2 = 0xAAAA, then R2 = 0x5555 with `addrA`=2 → `a` = 0xAAAA in the write cycle and 0x5555 the cycle after.
